// File: rtl/leaf_out_packetizer.sv
// Multi-port user-to-BFT output stage: per-port FIFOs, credit-gated round-robin arbiter.
// Optional per-port stall counters are built when LEAF_PKT_STATS_EN is defined.
module leaf_out_packetizer #(
    parameter int NUM_OUT_PORTS         = 2,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int PACKET_BITS           = 49,
    parameter int FIFO_AW               = 2,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]           din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                        vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                        ack_interface2user,
    input  logic [NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] dest_cfg,
    input  logic [NUM_OUT_PORTS-1:0]                        credit_return,
    input  logic                                            resend,
    input  logic                                            dout_ready,
    output logic [PACKET_BITS-1:0]                          dout_leaf_interface2bft
`ifdef LEAF_PKT_STATS_EN
    ,
    output logic [NUM_OUT_PORTS*16-1:0]                     stall_cnt
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int DW    = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int PW    = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam int CW    = NUM_ADDR_BITS + 1;
    localparam logic [CW-1:0]      CREDIT_MAX = {1'b1, {NUM_ADDR_BITS{1'b0}}};
    localparam logic [FIFO_AW:0]   ACK_LIM    = (FIFO_AW + 1)'(DEPTH - 1);

    logic [PAYLOAD_BITS-1:0]  mem_q    [NUM_OUT_PORTS][DEPTH];
    logic [PAYLOAD_BITS-1:0]  mem_d    [NUM_OUT_PORTS][DEPTH];
    logic [FIFO_AW-1:0]       wp_q     [NUM_OUT_PORTS];
    logic [FIFO_AW-1:0]       wp_d     [NUM_OUT_PORTS];
    logic [FIFO_AW-1:0]       rp_q     [NUM_OUT_PORTS];
    logic [FIFO_AW-1:0]       rp_d     [NUM_OUT_PORTS];
    logic [FIFO_AW:0]         cnt_q    [NUM_OUT_PORTS];
    logic [FIFO_AW:0]         cnt_d    [NUM_OUT_PORTS];
    logic [CW-1:0]            credit_q [NUM_OUT_PORTS];
    logic [CW-1:0]            credit_d [NUM_OUT_PORTS];
    logic [31:0]              csum     [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq_q    [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq_d    [NUM_OUT_PORTS];
    logic [NUM_OUT_PORTS-1:0] ack_q, ack_d;
    logic [PW-1:0]            rr_q, rr_d;
    logic [PACKET_BITS-1:0]   out_q, out_d;

    logic [NUM_OUT_PORTS-1:0] elig, push, pop;
    logic                     found, gnt, out_free;
    logic [PW-1:0]            win;
    logic [PACKET_BITS-1:0]   pkt;

    assign ack_interface2user      = ack_q;
    assign dout_leaf_interface2bft = resend ? '0 : out_q;
    assign out_free                = !out_q[PACKET_BITS-1] || dout_ready;

    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            elig[i] = (cnt_q[i] != '0) && (credit_q[i] != '0);
        end
    end

    // Search order starts at rr_ptr and wraps around all ports.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_OUT_PORTS; k++) begin
            if (!found && elig[(int'(rr_q) + k) % NUM_OUT_PORTS]) begin
                found = 1'b1;
                win   = PW'((int'(rr_q) + k) % NUM_OUT_PORTS);
            end
        end
        gnt = found && out_free && !resend;
        pkt = {1'b1, dest_cfg[int'(win)*DW +: DW], seq_q[win], mem_q[win][rp_q[win]]};
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt) begin
            if (int'(win) == NUM_OUT_PORTS - 1) rr_d = '0;
            else                                rr_d = win + 1'b1;
        end
    end

    // The held packet survives a resend; it is only replaced or retired otherwise.
    always_comb begin
        out_d = out_q;
        if (!resend) begin
            if (gnt)             out_d = pkt;
            else if (dout_ready) out_d = '0;
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            push[i] = vld_user2interface[i] && ack_q[i];
            pop[i]  = gnt && (win == PW'(i));
            if (push[i]) begin
                mem_d[i][wp_q[i]] = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
            wp_d[i] = push[i] ? wp_q[i] + 1'b1 : wp_q[i];
            rp_d[i] = pop[i]  ? rp_q[i] + 1'b1 : rp_q[i];
            cnt_d[i] = cnt_q[i];
            if (push[i] && !pop[i])      cnt_d[i] = cnt_q[i] + 1'b1;
            else if (!push[i] && pop[i]) cnt_d[i] = cnt_q[i] - 1'b1;
            ack_d[i] = cnt_d[i] < ACK_LIM;
            seq_d[i] = pop[i] ? seq_q[i] + 1'b1 : seq_q[i];
            csum[i] = 32'(credit_q[i])
                    + (credit_return[i] ? 32'(FREESPACE_UPDATE_SIZE) : 32'd0)
                    - (pop[i] ? 32'd1 : 32'd0);
            credit_d[i] = (csum[i] > 32'(CREDIT_MAX)) ? CREDIT_MAX : csum[i][CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                wp_q[i]     <= '0;
                rp_q[i]     <= '0;
                cnt_q[i]    <= '0;
                credit_q[i] <= CREDIT_MAX;
                seq_q[i]    <= '0;
            end
            ack_q <= '0;
            rr_q  <= '0;
            out_q <= '0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
            seq_q    <= seq_d;
            ack_q    <= ack_d;
            rr_q     <= rr_d;
            out_q    <= out_d;
        end
    end

`ifdef LEAF_PKT_STATS_EN
    logic [15:0] stall_q [NUM_OUT_PORTS];
    logic [15:0] stall_d [NUM_OUT_PORTS];

    always_comb begin
        stall_cnt = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            stall_d[i] = stall_q[i];
            if ((cnt_q[i] != '0) && (credit_q[i] == '0) && (stall_q[i] != 16'hFFFF)) begin
                stall_d[i] = stall_q[i] + 16'd1;
            end
            stall_cnt[i*16 +: 16] = stall_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) stall_q[i] <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Directed and randomized checks of leaf_out_packetizer against a queue-based model.
// Stall counters are compared as well when LEAF_PKT_STATS_EN is defined.
module tb_leaf_out_packetizer;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] din;
    logic [1:0]  vld;
    logic [1:0]  ack;
    logic [17:0] dest_cfg;
    logic [1:0]  cr;
    logic        rs;
    logic        rdy;
    logic [48:0] dout;
`ifdef LEAF_PKT_STATS_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    leaf_out_packetizer dut (
        .clk                     (clk),
        .reset                   (reset),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .dest_cfg                (dest_cfg),
        .credit_return           (cr),
        .resend                  (rs),
        .dout_ready              (rdy),
        .dout_leaf_interface2bft (dout)
`ifdef LEAF_PKT_STATS_EN
        ,
        .stall_cnt               (stall_cnt)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference state: plain queues and counters
    logic [31:0] q [2][$];
    int          credit [2];
    int          seq [2];
    int          stall_m [2];
    int          rr;
    logic [48:0] held;
    logic [1:0]  ack_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [1:0] acc;
        int w;
        int c;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                q[i].delete();
                credit[i]  = 128;
                seq[i]     = 0;
                stall_m[i] = 0;
            end
            rr    = 0;
            held  = '0;
            ack_m = 2'b00;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (q[i].size() > 0 && credit[i] == 0 && stall_m[i] < 65535) stall_m[i]++;
        end
        acc = vld & ack_m;
        w = -1;
        if (!rs && (!held[48] || rdy)) begin
            for (int k = 0; k < 2; k++) begin
                int idx;
                idx = (rr + k) % 2;
                if (w < 0 && q[idx].size() > 0 && credit[idx] > 0) w = idx;
            end
        end
        if (w >= 0) begin
            logic [8:0] d;
            logic [6:0] s;
            d = dest_cfg[w*9 +: 9];
            s = 7'(seq[w]);
            held = {1'b1, d, s, q[w].pop_front()};
            seq[w] = (seq[w] + 1) % 128;
            rr = (w + 1) % 2;
        end else if (!rs && rdy) begin
            held = '0;
        end
        for (int i = 0; i < 2; i++) begin
            c = credit[i] - ((w == i) ? 1 : 0) + (cr[i] ? 64 : 0);
            credit[i] = (c > 128) ? 128 : c;
            if (acc[i]) q[i].push_back(din[i*32 +: 32]);
            ack_m[i] = (q[i].size() < 3);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] v, input logic [63:0] d,
                        input logic ready, input logic hold, input logic [1:0] ret);
        reset = r;
        vld   = v;
        din   = d;
        rdy   = ready;
        rs    = hold;
        cr    = ret;
        @(posedge clk);
        model_edge();
        #1;
        chk("dout", dout, rs ? 49'd0 : held);
        chk("ack", ack, ack_m);
`ifdef LEAF_PKT_STATS_EN
        chk("stall0", stall_cnt[15:0], stall_m[0]);
        chk("stall1", stall_cnt[31:16], stall_m[1]);
`endif
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [48:0] e;
        logic [48:0] o;
        int cnt;
        dest_cfg = {5'd17, 4'd9, 5'd5, 4'd3};
        reset = 1'b1; vld = '0; din = '0; rdy = 1'b1; rs = 1'b0; cr = '0;

        // reset state
        repeat (3) step(1'b1, 2'b11, rnd64(), 1'b1, 1'b0, 2'b00);
        chk("rst_dout", dout, 49'd0);
        chk("rst_ack", ack, 2'b00);
        step(1'b0, 2'b00, 64'd0, 1'b1, 1'b0, 2'b00);
        chk("ack_after_rst", ack, 2'b11);

        // single-word latency and packet format
        step(1'b0, 2'b01, {32'd0, 32'hDEADBEEF}, 1'b1, 1'b0, 2'b00);
        step(1'b0, 2'b00, 64'd0, 1'b1, 1'b0, 2'b00);
        e = {1'b1, 5'd5, 4'd3, 7'd0, 32'hDEADBEEF};
        chk("pkt_first", dout, e);
        step(1'b0, 2'b01, {32'd0, 32'hCAFEF00D}, 1'b1, 1'b0, 2'b00);
        step(1'b0, 2'b00, 64'd0, 1'b1, 1'b0, 2'b00);
        e = {1'b1, 5'd5, 4'd3, 7'd1, 32'hCAFEF00D};
        chk("pkt_seq1", dout, e);

        // both ports streaming: alternation, one packet per cycle
        repeat (20) step(1'b0, 2'b11, rnd64(), 1'b1, 1'b0, 2'b00);

        // backpressure then drain
        repeat (10) step(1'b0, 2'b11, rnd64(), 1'b0, 1'b0, 2'b00);
        chk("bp_ack_low", ack, 2'b00);
        repeat (10) step(1'b0, 2'b00, rnd64(), 1'b1, 1'b0, 2'b00);

        // resend hold
        repeat (3) step(1'b0, 2'b11, rnd64(), 1'b1, 1'b0, 2'b00);
        repeat (5) begin
            step(1'b0, 2'b11, rnd64(), 1'b1, 1'b1, 2'b00);
            chk("resend_zero", dout, 49'd0);
        end
        repeat (10) step(1'b0, 2'b11, rnd64(), 1'b1, 1'b0, 2'b00);

        // reset mid-burst
        repeat (4) step(1'b0, 2'b11, rnd64(), 1'b1, 1'b0, 2'b00);
        step(1'b1, 2'b11, rnd64(), 1'b1, 1'b0, 2'b00);
        chk("midrst_dout", dout, 49'd0);
        chk("midrst_ack", ack, 2'b00);
        step(1'b0, 2'b11, rnd64(), 1'b1, 1'b0, 2'b00);
        chk("midrst_ack_back", ack, 2'b11);
        step(1'b0, 2'b11, rnd64(), 1'b1, 1'b0, 2'b00);
        step(1'b0, 2'b11, rnd64(), 1'b1, 1'b0, 2'b00);
        o = dout;
        chk("midrst_first_dest", o[47:39], 9'h053);
        chk("midrst_first_seq", o[38:32], 7'd0);
        repeat (6) step(1'b0, 2'b11, rnd64(), 1'b1, 1'b0, 2'b00);

        // credit exhaustion on port 0
        repeat (2) step(1'b1, 2'b00, 64'd0, 1'b1, 1'b0, 2'b00);
        step(1'b0, 2'b00, 64'd0, 1'b1, 1'b0, 2'b00);
        cnt = 0;
        repeat (140) begin
            step(1'b0, 2'b01, rnd64(), 1'b1, 1'b0, 2'b00);
            if (dout[48]) cnt++;
        end
        chk("credit_128", cnt, 128);
        chk("credit_withheld", dout, 49'd0);
        cnt = 0;
        step(1'b0, 2'b01, rnd64(), 1'b1, 1'b0, 2'b01);
        if (dout[48]) cnt++;
        repeat (69) begin
            step(1'b0, 2'b01, rnd64(), 1'b1, 1'b0, 2'b00);
            if (dout[48]) cnt++;
        end
        chk("credit_64_more", cnt, 64);

        // randomized traffic
        repeat (1500) begin
            step(($urandom_range(0, 499) == 0),
                 2'($urandom_range(0, 3)),
                 rnd64(),
                 ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 19) == 0),
                 {($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
